// File: rtl/bench_signature_compactor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bench_signature_compactor                                      |
// | Purpose : Samples a benchmark netlist's primary outputs for a programmed |
// |           number of valid cycles and folds them into a MISR. The final   |
// |           signature is compared to a golden value and pass is reported.  |
// | Ports   : clock, reset_n      - rising-edge clock, async active-low rst  |
// |           start, num_cycles,  - begin a run; count and golden signature  |
// |           expected              are latched when start is accepted       |
// |           abort               - cancel a run in progress                 |
// |           resp_valid, resp    - response sample stream                   |
// |           busy, done, pass    - run status (all registered)              |
// |           signature           - current MISR contents                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bench_signature_compactor #(
  parameter int                 IN_W  = 1,
  parameter int                 SIG_W = 16,
  parameter logic [SIG_W-1:0]   POLY  = 16'h1021,
  parameter logic [SIG_W-1:0]   SEED  = 16'hFFFF,
  parameter int                 CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [SIG_W-1:0] expected,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic [IN_W-1:0]  resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [SIG_W-1:0] exp_q,       exp_d;
  logic [SIG_W-1:0] sig_q,       sig_d;
  logic             pass_q,      pass_d;

  logic [SIG_W-1:0] w_resp_ext;
  logic [SIG_W-1:0] w_sig_next;

  assign w_resp_ext = SIG_W'(resp);

  // One MISR step: shift left, fold the outgoing MSB back through the
  // polynomial taps, then XOR in the parallel response sample.
  assign w_sig_next = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ w_resp_ext;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    exp_d       = exp_q;
    sig_d       = sig_q;
    pass_d      = pass_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = num_cycles;
          exp_d       = expected;
          sig_d       = SEED;
          pass_d      = 1'b0;
          state_d     = (num_cycles == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        // Abort wins over a sample offered in the same cycle.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (resp_valid) begin
          sig_d       = w_sig_next;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        pass_d  = (sig_q == exp_q);
        state_d = ST_IDLE;
        // A start here begins the next run immediately; its clear of pass
        // takes precedence over the compare of the run just finished.
        if (start) begin
          remaining_d = num_cycles;
          exp_d       = expected;
          sig_d       = SEED;
          pass_d      = 1'b0;
          state_d     = (num_cycles == '0) ? ST_DONE : ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      exp_q       <= '0;
      sig_q       <= SEED;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      exp_q       <= exp_d;
      sig_q       <= sig_d;
      pass_q      <= pass_d;
    end
  end

  // Status outputs decode directly from registered state.
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule
`default_nettype wire
